mem_port_tester: RTL and testbench
==================================

Name: mem_port_tester

Overview:
Built-in traffic generator and checker for one client port of the 4-port LPDDR2 RAM interface (port 0 by default).
- Acts as the port master: on start, writes NUM_WORDS words of a known pattern from BASE_ADDR upward, then reads them back.
- Compares returned data against the regenerated pattern and reports pass/fail, error count and first failing address.
- Sits beside the frame buffer address generator in the image capture top level for board bring-up and memory soak testing.

Parameters:
ADDR_W, 24, port address width
DATA_W, 32, port data width
BASE_ADDR, 24'h000000, first word address tested
NUM_WORDS, 512, words written then read; legal range 1 to 2^ADDR_W-BASE_ADDR
TST_PATT, 32'hFFFFFFFF, constant pattern XORed with address (pattern = TST_PATT ^ zero-extended addr)
MAX_OUTSTANDING, 8, maximum reads issued but not yet returned
TIMEOUT, 4096, cycles allowed with outstanding reads and no rd_data_valid

Ports:
CLOCK_125_p  in  1  clock
reset  in  1  synchronous, active-high
start  in  1  one-cycle pulse, begins a test run when idle
wr_rdy  in  1  port accepts a write this cycle
wr_en  out  1  write request
wr_addr  out  ADDR_W  write address
wr_data  out  DATA_W  write data
rd_rdy  in  1  port accepts a read this cycle
rd_en  out  1  read request
rd_addr  out  ADDR_W  read address
rd_data  in  DATA_W  returned read data, in order
rd_data_valid  in  1  rd_data valid this cycle
busy  out  1  run in progress
pass  out  1  run finished with zero errors (sticky until next start/reset)
fail  out  1  any mismatch, spurious return or timeout (sticky)
err_count  out  16  mismatches, saturating at 16'hFFFF
first_err_addr  out  ADDR_W  address of first mismatch

Behaviour:
- Reset: state IDLE; all outputs 0; counters cleared. Reset mid-run aborts immediately; no further requests are issued.
- FSM states:
  - IDLE: start -> WRITE; clear pass/fail/err_count/first_err_addr; addresses = BASE_ADDR.
  - WRITE: wr_en = 1 only while wr_rdy = 1; a beat transfers on an edge with wr_en & wr_rdy. wr_addr increments per beat. After beat NUM_WORDS-1 -> READ.
  - READ: rd_en = rd_rdy & (outstanding < MAX_OUTSTANDING); issue addr increments per accepted read. After NUM_WORDS issued -> DRAIN.
  - DRAIN: wait until all returns arrive (outstanding = 0), then -> DONE.
  - DONE: pass = (err_count = 0) & no timeout; busy = 0; start -> WRITE (new run).
- wr_en/wr_data/wr_addr and rd_en/rd_addr are combinational from registered state and rd_rdy/wr_rdy; data and address stay stable while the handshake is stalled.
- busy = 1 in WRITE, READ and DRAIN. start is ignored while busy.
- Outstanding counter:
  - +1 on rd_en & rd_rdy; -1 on rd_data_valid; net 0 when both happen in the same cycle.
  - rd_data_valid with outstanding = 0 is spurious: set fail, do not decrement.
- Check:
  - A separate check-address counter starts at BASE_ADDR and advances per rd_data_valid.
  - Expected data = pattern(check addr). A mismatch increments err_count (saturating) and sets fail; first_err_addr is captured only on the first mismatch.
  - Compare is registered; fail/err_count update 1 cycle after the returning beat.
- Timeout: counter runs in READ/DRAIN while outstanding > 0 and resets on each rd_data_valid. Reaching TIMEOUT sets fail and forces DONE.
- Address arithmetic is ADDR_W-bit modulo; no wrap occurs within the legal NUM_WORDS range.

Optional Feature:
MEM_TST_LFSR_EN
- Defined: the pattern is a 32-bit Galois LFSR (taps 32,22,2,1, seed TST_PATT, never zero) advanced once per write beat. The check side runs an identical LFSR advanced per rd_data_valid.
- Undefined: address-XOR pattern as above; no LFSR logic synthesized.

Decomposition:
- Package mem_tst_pkg: FSM state enum (IDLE, WRITE, READ, DRAIN, DONE), LFSR tap constant, err_count width constant.
- Sub-module mem_tst_patgen: pattern source with load/advance/addr inputs. Instantiated twice: write side and check side.

Test Plan:
- Ideal port (wr_rdy = rd_rdy = 1, 4-cycle read latency), NUM_WORDS = 16 -> 16 write beats in 16 cycles, 16 reads, pass = 1, fail = 0, err_count = 0.
- Randomly deasserted wr_rdy/rd_rdy -> no beat lost or duplicated; wr_addr/wr_data held during stall; pass = 1.
- Memory model corrupts word at BASE_ADDR+5 and +9 -> fail = 1, err_count = 2, first_err_addr = BASE_ADDR+5, pass = 0.
- Read latency 20, MAX_OUTSTANDING = 8 -> outstanding never exceeds 8. Model drops one return -> fail after TIMEOUT cycles, state DONE.
- Spurious rd_data_valid in IDLE -> fail = 1. Reset asserted mid-WRITE -> next cycle wr_en = 0, busy = 0, all flags 0.
- MEM_TST_LFSR_EN defined -> written sequence matches reference LFSR from seed 32'hFFFFFFFF; pass = 1.

Source files
------------

// File: rtl/mem_tst_pkg.sv
// Shared types and constants for the memory port tester.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: FSM state enum, Galois LFSR tap mask and step function, error counter width.
package mem_tst_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        DONE
    } tst_state_t;

    // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1.
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    localparam int ERR_CNT_W = 16;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/mem_port_tester_if.sv
// Client-port bundle between the tester (master) and one RAM interface port (slave).
// Latency: n/a (wires only).
// Backpressure: wr_rdy/rd_rdy qualify wr_en/rd_en; read data returns in order on rd_data_valid.
// Signals: wr_rdy, wr_en, wr_addr, wr_data, rd_rdy, rd_en, rd_addr, rd_data, rd_data_valid.
interface mem_port_tester_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32
);
    logic              wr_rdy;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_rdy;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_data_valid;

    modport master (
        input  wr_rdy, rd_rdy, rd_data, rd_data_valid,
        output wr_en, wr_addr, wr_data, rd_en, rd_addr
    );

    modport slave (
        output wr_rdy, rd_rdy, rd_data, rd_data_valid,
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr
    );
endinterface

// File: rtl/mem_tst_patgen.sv
// Test pattern source: address-XOR pattern, or a Galois LFSR when MEM_TST_LFSR_EN is defined.
// Latency: pattern is combinational from current state; LFSR steps on the edge after advance.
// Backpressure: none; advance only when the owning side consumes a word.
// Ports: CLOCK_125_p, reset (sync, high), load (reseed), advance (step), addr (word address), pattern (out).
module mem_tst_patgen
    import mem_tst_pkg::*;
#(
    parameter int                ADDR_W   = 24,
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] TST_PATT = '1
) (
    input  logic              CLOCK_125_p,
    input  logic              reset,
    input  logic              load,
    input  logic              advance,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] pattern
);

`ifdef MEM_TST_LFSR_EN
    // An all-zero seed would lock the LFSR, so substitute 1.
    localparam logic [31:0] SEED = (32'(TST_PATT) == 32'h0) ? 32'h1 : 32'(TST_PATT);

    logic [31:0] lfsr_q;

    always_ff @(posedge CLOCK_125_p) begin
        if (reset || load) begin
            lfsr_q <= SEED;
        end else if (advance) begin
            lfsr_q <= lfsr_step(lfsr_q);
        end
    end

    assign pattern = DATA_W'(lfsr_q);

    logic unused_addr;
    assign unused_addr = ^addr;
`else
    assign pattern = TST_PATT ^ DATA_W'(addr);

    logic unused_ctl;
    assign unused_ctl = ^{CLOCK_125_p, reset, load, advance};
`endif

endmodule

// File: rtl/mem_port_tester.sv
// Write-then-read-back traffic generator and checker for one LPDDR2 client port (MEM_TST_LFSR_EN selects LFSR data).
// Latency: requests combinational from state; mismatch/err_count/fail update 1 cycle after the returning beat.
// Backpressure: wr_en/rd_en only while wr_rdy/rd_rdy; reads also capped at MAX_OUTSTANDING in flight.
// Ports: CLOCK_125_p, reset (sync, high), start, mem (master side of mem_port_tester_if),
//        busy, pass, fail, err_count (saturating), first_err_addr.
module mem_port_tester
    import mem_tst_pkg::*;
#(
    parameter int                ADDR_W          = 24,
    parameter int                DATA_W          = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR       = '0,
    parameter int                NUM_WORDS       = 512,
    parameter logic [DATA_W-1:0] TST_PATT        = '1,
    parameter int                MAX_OUTSTANDING = 8,
    parameter int                TIMEOUT         = 4096
) (
    input  logic                 CLOCK_125_p,
    input  logic                 reset,
    input  logic                 start,
    mem_port_tester_if.master    mem,
    output logic                 busy,
    output logic                 pass,
    output logic                 fail,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [ADDR_W-1:0]    first_err_addr
);

    localparam int                OUT_W     = $clog2(MAX_OUTSTANDING + 1);
    localparam int                TMO_W     = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BASE_ADDR + NUM_WORDS - 1);

    tst_state_t state, state_nxt;

    logic [ADDR_W-1:0]    wr_addr_q, rd_addr_q, chk_addr_q;
    logic [OUT_W-1:0]     out_cnt;
    logic [TMO_W-1:0]     tmo_cnt;
    logic [ERR_CNT_W-1:0] err_cnt_q;
    logic [ADDR_W-1:0]    first_err_q;
    logic                 fail_q;

    logic [DATA_W-1:0]    wr_patt, chk_patt;

    logic              wr_en_c, rd_en_c, busy_c, pass_c;
    logic [ADDR_W-1:0] wr_addr_c, rd_addr_c;
    logic [DATA_W-1:0] wr_data_c;

    logic start_run, ret_ok, ret_spur, mismatch, tmo_run, tmo_hit;

    assign start_run = start && (state == IDLE || state == DONE);
    // A return is only legitimate if a read is actually in flight.
    assign ret_ok    = mem.rd_data_valid && (out_cnt != '0);
    assign ret_spur  = mem.rd_data_valid && (out_cnt == '0);
    assign mismatch  = ret_ok && (mem.rd_data != chk_patt);
    assign tmo_run   = (state == READ || state == DRAIN) && (out_cnt != '0) && !mem.rd_data_valid;
    assign tmo_hit   = tmo_run && (tmo_cnt == TMO_W'(TIMEOUT - 1));

    // State register
    always_ff @(posedge CLOCK_125_p) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (start) state_nxt = WRITE;
            WRITE: if (wr_en_c && wr_addr_q == LAST_ADDR) state_nxt = READ;
            READ: begin
                if (tmo_hit) begin
                    state_nxt = DONE;
                end else if (rd_en_c && rd_addr_q == LAST_ADDR) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: if (tmo_hit || out_cnt == '0) state_nxt = DONE;
            DONE:  if (start) state_nxt = WRITE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: address/data are driven from registers for the whole phase so they
    // hold still while the port stalls; outside their phase they read as zero.
    always_comb begin
        wr_en_c   = 1'b0;
        wr_addr_c = '0;
        wr_data_c = '0;
        rd_en_c   = 1'b0;
        rd_addr_c = '0;
        busy_c    = 1'b0;
        pass_c    = 1'b0;
        unique case (state)
            WRITE: begin
                wr_en_c   = mem.wr_rdy;
                wr_addr_c = wr_addr_q;
                wr_data_c = wr_patt;
                busy_c    = 1'b1;
            end
            READ: begin
                rd_en_c   = mem.rd_rdy && (out_cnt < OUT_W'(MAX_OUTSTANDING));
                rd_addr_c = rd_addr_q;
                busy_c    = 1'b1;
            end
            DRAIN:   busy_c = 1'b1;
            DONE:    pass_c = !fail_q;
            default: ;
        endcase
    end

    assign mem.wr_en   = wr_en_c;
    assign mem.wr_addr = wr_addr_c;
    assign mem.wr_data = wr_data_c;
    assign mem.rd_en   = rd_en_c;
    assign mem.rd_addr = rd_addr_c;

    assign busy           = busy_c;
    assign pass           = pass_c;
    assign fail           = fail_q;
    assign err_count      = err_cnt_q;
    assign first_err_addr = first_err_q;

    // Datapath: address counters, in-flight count, timeout and result flags.
    always_ff @(posedge CLOCK_125_p) begin
        if (reset) begin
            wr_addr_q   <= BASE_ADDR;
            rd_addr_q   <= BASE_ADDR;
            chk_addr_q  <= BASE_ADDR;
            out_cnt     <= '0;
            tmo_cnt     <= '0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            fail_q      <= 1'b0;
        end else if (start_run) begin
            // Late returns from an aborted run are forgotten along with their count.
            wr_addr_q   <= BASE_ADDR;
            rd_addr_q   <= BASE_ADDR;
            chk_addr_q  <= BASE_ADDR;
            out_cnt     <= '0;
            tmo_cnt     <= '0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            fail_q      <= 1'b0;
        end else begin
            if (wr_en_c) wr_addr_q  <= wr_addr_q + ADDR_W'(1);
            if (rd_en_c) rd_addr_q  <= rd_addr_q + ADDR_W'(1);
            if (ret_ok)  chk_addr_q <= chk_addr_q + ADDR_W'(1);

            out_cnt <= out_cnt + OUT_W'(rd_en_c) - OUT_W'(ret_ok);
            tmo_cnt <= tmo_run ? tmo_cnt + TMO_W'(1) : '0;

            if (mismatch) begin
                if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
                if (err_cnt_q == '0) first_err_q <= chk_addr_q;
            end

            if (mismatch || ret_spur || tmo_hit) fail_q <= 1'b1;
        end
    end

    mem_tst_patgen #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .TST_PATT (TST_PATT)
    ) u_wr_patgen (
        .CLOCK_125_p (CLOCK_125_p),
        .reset       (reset),
        .load        (start_run),
        .advance     (wr_en_c),
        .addr        (wr_addr_q),
        .pattern     (wr_patt)
    );

    mem_tst_patgen #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .TST_PATT (TST_PATT)
    ) u_chk_patgen (
        .CLOCK_125_p (CLOCK_125_p),
        .reset       (reset),
        .load        (start_run),
        .advance     (ret_ok),
        .addr        (chk_addr_q),
        .pattern     (chk_patt)
    );

endmodule

// File: tb/tb_mem_port_tester.sv
// Bench for mem_port_tester: memory model with configurable latency, stalls, corruption and dropped returns.
// Latency: n/a.
// Backpressure: model drives wr_rdy/rd_rdy either constantly high or randomly low.
`timescale 1ns/1ps
module tb_mem_port_tester;

    localparam int          ADDR_W = 24;
    localparam int          DATA_W = 32;
    localparam logic [23:0] BASE   = 24'h000100;
    localparam int          NUM    = 16;
    localparam int          MAXO   = 8;
    localparam int          TMO    = 64;

    logic        clk;
    logic        reset;
    logic        start;
    logic        busy, pass, fail;
    logic [15:0] err_count;
    logic [23:0] first_err_addr;

    mem_port_tester_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m_if ();

    mem_port_tester #(
        .ADDR_W          (ADDR_W),
        .DATA_W          (DATA_W),
        .BASE_ADDR       (BASE),
        .NUM_WORDS       (NUM),
        .TST_PATT        (32'hFFFFFFFF),
        .MAX_OUTSTANDING (MAXO),
        .TIMEOUT         (TMO)
    ) dut (
        .CLOCK_125_p    (clk),
        .reset          (reset),
        .start          (start),
        .mem            (m_if),
        .busy           (busy),
        .pass           (pass),
        .fail           (fail),
        .err_count      (err_count),
        .first_err_addr (first_err_addr)
    );

    initial begin
        clk = 1'b0;
        forever #4 clk = ~clk;
    end

    // Reference pattern for write index idx.
    function automatic logic [31:0] exp_patt(input int idx);
        logic [31:0] s;
`ifdef MEM_TST_LFSR_EN
        s = 32'hFFFFFFFF;
        for (int i = 0; i < idx; i++) s = s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
`else
        s = 32'hFFFFFFFF ^ {8'h00, BASE + 24'(idx)};
`endif
        return s;
    endfunction

    // ---------------- memory model ----------------
    typedef struct {
        int          due;
        logic [31:0] data;
    } ret_t;

    int          lat = 4;
    bit          rnd = 0;
    int          cor_a = -1, cor_b = -1, drop = -1;
    bit          spur_req = 0, spur_now = 0;
    int          cyc = 0;
    int          wr_cnt = 0, rd_cnt = 0, ret_idx = 0;
    int          seq_err = 0, hold_err = 0;
    int          tb_out = 0, tb_max = 0;
    int          first_wr_cyc = 0, last_wr_cyc = 0, last_ret_cyc = 0;
    logic [31:0] mem_arr [NUM];
    ret_t        rq [$];

    initial begin : model
        bit          wr_hs, rd_hs;
        logic [23:0] wa, ra, prev_wa, prev_ra;
        logic [31:0] wd, prev_wd;
        bit          prev_wstall, prev_rstall;
        ret_t        e;
        int          idx;
        prev_wstall = 0; prev_rstall = 0;
        prev_wa = '0; prev_ra = '0; prev_wd = '0;
        m_if.wr_rdy = 1'b0;
        m_if.rd_rdy = 1'b0;
        m_if.rd_data = '0;
        m_if.rd_data_valid = 1'b0;
        forever begin
            @(negedge clk);
            wr_hs = m_if.wr_en && m_if.wr_rdy;
            rd_hs = m_if.rd_en && m_if.rd_rdy;
            wa = m_if.wr_addr;
            wd = m_if.wr_data;
            ra = m_if.rd_addr;
            if (prev_wstall && m_if.wr_addr != '0 &&
                (m_if.wr_addr != prev_wa || m_if.wr_data != prev_wd)) hold_err++;
            if (prev_rstall && m_if.rd_addr != '0 && m_if.rd_addr != prev_ra) hold_err++;
            prev_wstall = (m_if.wr_addr != '0) && !m_if.wr_rdy;
            prev_rstall = (m_if.rd_addr != '0) && !m_if.rd_en;
            prev_wa = wa; prev_wd = wd; prev_ra = ra;
            if (wr_hs) begin
                if (wa != BASE + 24'(wr_cnt) || wd != exp_patt(wr_cnt)) seq_err++;
                if (wa >= BASE && wa < BASE + 24'(NUM)) mem_arr[int'(wa - BASE)] = wd;
                if (wr_cnt == 0) first_wr_cyc = cyc;
                last_wr_cyc = cyc;
                wr_cnt++;
            end
            if (m_if.rd_data_valid && !spur_now) tb_out--;
            if (rd_hs) begin
                if (ra != BASE + 24'(rd_cnt)) seq_err++;
                rd_cnt++;
                tb_out++;
            end
            if (tb_out > tb_max) tb_max = tb_out;

            @(posedge clk);
            #1;
            cyc++;
            if (rd_hs) begin
                idx = int'(ra - BASE);
                e.due = cyc + lat;
                e.data = (idx >= 0 && idx < NUM) ? mem_arr[idx] : 32'h0;
                if (idx == cor_a || idx == cor_b) e.data = e.data ^ 32'h1;
                rq.push_back(e);
            end
            m_if.rd_data_valid = 1'b0;
            m_if.rd_data = '0;
            spur_now = 0;
            if (spur_req) begin
                m_if.rd_data_valid = 1'b1;
                spur_req = 0;
                spur_now = 1;
            end else if (rq.size() > 0 && rq[0].due <= cyc) begin
                e = rq.pop_front();
                if (ret_idx != drop) begin
                    m_if.rd_data_valid = 1'b1;
                    m_if.rd_data = e.data;
                    last_ret_cyc = cyc;
                end
                ret_idx++;
            end
            m_if.wr_rdy = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            m_if.rd_rdy = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    // ---------------- checking ----------------
    int total = 0;
    int bad = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        int          lat;
        bit          rnd;
        int          cor_a;
        int          cor_b;
        int          drop;
        bit          exp_pass;
        bit          exp_fail;
        int          exp_err;
        logic [23:0] exp_first;
        int          exp_max;
        bit          exp_tmo;
        bit          chk_span;
    } vec_t;

    task automatic setup(input int l, input bit r, input int ca, input int cb, input int dr);
        @(negedge clk);
        lat = l; rnd = r; cor_a = ca; cor_b = cb; drop = dr;
        rq.delete();
        wr_cnt = 0; rd_cnt = 0; ret_idx = 0; seq_err = 0; hold_err = 0;
        tb_out = 0; tb_max = 0; last_ret_cyc = 0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        bit done;
        done = 0;
        setup(v.lat, v.rnd, v.cor_a, v.cor_b, v.drop);
        pulse_start();
        for (int n = 0; n < 3000 && !done; n++) begin
            @(negedge clk);
            if (!busy) done = 1;
        end
        check({v.name, " run_end"}, 64'(done), 64'd1);
        check({v.name, " pass"}, 64'(pass), 64'(v.exp_pass));
        check({v.name, " fail"}, 64'(fail), 64'(v.exp_fail));
        check({v.name, " err_count"}, 64'(err_count), 64'(v.exp_err));
        check({v.name, " first_err_addr"}, 64'(first_err_addr), 64'(v.exp_first));
        check({v.name, " writes"}, 64'(wr_cnt), 64'(NUM));
        check({v.name, " reads"}, 64'(rd_cnt), 64'(NUM));
        check({v.name, " seq_err"}, 64'(seq_err), 64'd0);
        check({v.name, " hold_err"}, 64'(hold_err), 64'd0);
        if (v.chk_span) check({v.name, " wr_span"}, 64'(last_wr_cyc - first_wr_cyc + 1), 64'(NUM));
        if (v.exp_max != 0) check({v.name, " max_out"}, 64'(tb_max), 64'(v.exp_max));
        else check({v.name, " max_out_le"}, 64'(tb_max <= MAXO), 64'd1);
        if (v.exp_tmo) check({v.name, " tmo_delay"}, 64'(cyc - last_ret_cyc), 64'(TMO + 1));
    endtask

    initial begin : main
        vec_t vt [5];
        int   wr_before;
        vt[0] = '{"ideal",   4,  0, -1, -1, -1, 1, 0, 0, 24'h0,    0, 0, 1};
        vt[1] = '{"stall",   4,  1, -1, -1, -1, 1, 0, 0, 24'h0,    0, 0, 0};
        vt[2] = '{"corrupt", 4,  0,  5,  9, -1, 0, 1, 2, BASE + 5, 0, 0, 0};
        vt[3] = '{"lat20",   20, 0, -1, -1, -1, 1, 0, 0, 24'h0,    8, 0, 1};
        vt[4] = '{"drop",    4,  0, -1, -1,  7, 0, 1, 8, BASE + 7, 0, 1, 0};

        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst busy", 64'(busy), 64'd0);
        check("rst pass", 64'(pass), 64'd0);
        check("rst fail", 64'(fail), 64'd0);
        check("rst err_count", 64'(err_count), 64'd0);
        check("rst wr_en", 64'(m_if.wr_en), 64'd0);
        check("rst rd_en", 64'(m_if.rd_en), 64'd0);
        @(posedge clk); #1 reset = 1'b0;

        // Spurious return while idle.
        @(negedge clk);
        spur_req = 1;
        repeat (2) @(negedge clk);
        check("spur_idle fail", 64'(fail), 64'd1);
        check("spur_idle pass", 64'(pass), 64'd0);
        check("spur_idle busy", 64'(busy), 64'd0);

        for (int i = 0; i < 5; i++) run_vec(vt[i]);

        // Reset in the middle of the write phase, after a spurious return has set fail.
        setup(4, 0, -1, -1, -1);
        pulse_start();
        repeat (3) @(negedge clk);
        spur_req = 1;
        repeat (2) @(negedge clk);
        check("midwr fail_before", 64'(fail), 64'd1);
        check("midwr busy_before", 64'(busy), 64'd1);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        wr_before = wr_cnt;
        check("midwr wr_en", 64'(m_if.wr_en), 64'd0);
        check("midwr busy", 64'(busy), 64'd0);
        check("midwr fail", 64'(fail), 64'd0);
        check("midwr pass", 64'(pass), 64'd0);
        check("midwr err_count", 64'(err_count), 64'd0);
        check("midwr first_err_addr", 64'(first_err_addr), 64'd0);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check("midwr no_more_writes", 64'(wr_cnt), 64'(wr_before));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1);
    end

endmodule
